// File: rtl/cic_decim_norm_fifo.sv
// Removes the 2^SHIFT CIC gain (round-half-up), narrows to width_W bits and buffers in a DEPTH-entry FIFO.
// Build option CIC_NORM_SAT_EN: saturate out-of-range results and drive sat_flag; otherwise results wrap.
module cic_decim_norm_fifo #(
    parameter int width_H = 5,
    parameter int width_W = 20,
    parameter int SHIFT   = 5,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_i_en,
    input  logic [width_H+width_W-1:0] data_i,
    input  logic                       data_o_rdy,
    output logic                       data_o_en,
    output logic [width_W-1:0]         data_o,
    output logic                       sat_flag,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int SUMW = width_H + width_W + 1;
`ifdef CIC_NORM_SAT_EN
    localparam int QW = SUMW - SHIFT;
`else
    localparam int QW = width_W;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam logic signed [SUMW-1:0] RND = SUMW'(1) <<< (SHIFT - 1);

    logic                 r_v1;
    logic [QW-1:0]        r_q;
    logic                 r_v2;
    logic [width_W-1:0]   r_s2;
    logic [width_W-1:0]   r_mem [DEPTH];
    logic [PW-1:0]        r_wr;
    logic [PW-1:0]        r_rd;
    logic [PW:0]          r_level;
    logic [7:0]           r_drop;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // The shift is folded into stage 1's register input so only the bits stage 2 needs are stored;
    // the two-edge latency to the FIFO push is unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_q  <= '0;
        end else begin
            r_v1 <= data_i_en;
            r_q  <= QW'(($signed(SUMW'($signed(data_i))) + RND) >>> SHIFT);
        end
    end

`ifdef CIC_NORM_SAT_EN
    logic r_sat2;
    logic r_sat_flag;
    logic w_ovf;

    // Out of range whenever the bits above the output sign bit are not all copies of it.
    assign w_ovf = !((&r_q[QW-1:width_W-1]) || !(|r_q[QW-1:width_W-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r_s2       <= '0;
            r_sat2     <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            r_v2       <= r_v1;
            r_s2       <= w_ovf ? {r_q[QW-1], {(width_W-1){~r_q[QW-1]}}} : r_q[width_W-1:0];
            r_sat2     <= w_ovf;
            r_sat_flag <= r_v2 && r_sat2;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else begin
            r_v2 <= r_v1;
            r_s2 <= r_q;
        end
    end

    assign sat_flag = 1'b0;
`endif

    // A push into a full FIFO still succeeds when the head is popped on the same edge.
    assign w_full = (r_level == (PW+1)'(DEPTH));
    assign w_pop  = (r_level != '0) && data_o_rdy;
    assign w_push = r_v2 && (!w_full || w_pop);
    assign w_drop = r_v2 && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr] <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign data_o_en  = (r_level != '0);
    assign data_o     = r_mem[r_rd];
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_cic_decim_norm_fifo.sv
// Bench for cic_decim_norm_fifo: directed and random stimulus against an arithmetic reference model.
module tb_cic_decim_norm_fifo;

    localparam int WH = 5;
    localparam int WW = 20;
    localparam int SH = 5;
    localparam int DP = 4;

    localparam longint HALF = longint'(1) << (SH - 1);
    localparam longint NDIV = longint'(1) << SH;
    localparam longint OMAX = (longint'(1) << (WW - 1)) - 1;
    localparam longint OMIN = -(longint'(1) << (WW - 1));
    localparam longint OMOD = longint'(1) << WW;

    logic                 clk;
    logic                 rst_n;
    logic                 data_i_en;
    logic [WH+WW-1:0]     data_i;
    logic                 data_o_rdy;
    logic                 data_o_en;
    logic [WW-1:0]        data_o;
    logic                 sat_flag;
    logic [7:0]           drop_cnt;
    logic [$clog2(DP):0]  fifo_level;

    cic_decim_norm_fifo #(
        .width_H (WH),
        .width_W (WW),
        .SHIFT   (SH),
        .DEPTH   (DP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i_en  (data_i_en),
        .data_i     (data_i),
        .data_o_rdy (data_o_rdy),
        .data_o_en  (data_o_en),
        .data_o     (data_o),
        .sat_flag   (sat_flag),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: two-edge delay line feeding a bounded queue.
    bit pv [2];
    int pq [2];
    bit ps [2];
    int mq [$];
    int mdrop;
    bit msat;

    bit rec;
    int got [$];
    int satseen;

    int rin  [5] = '{16, 15, -16, -17, 0};
    int rexp [5] = '{1, 0, 0, -1, 0};

    function automatic void norm(input longint x, output int q, output bit s);
        longint v;
        longint t;
        v = x + HALF;
        t = (v >= 0) ? v / NDIV : -((-v + NDIV - 1) / NDIV);
        s = 1'b0;
`ifdef CIC_NORM_SAT_EN
        if (t > OMAX) begin
            t = OMAX;
            s = 1'b1;
        end else if (t < OMIN) begin
            t = OMIN;
            s = 1'b1;
        end
`else
        t = ((t % OMOD) + OMOD) % OMOD;
        if (t > OMAX) t = t - OMOD;
`endif
        q = int'(t);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        mq.delete();
        mdrop = 0;
        msat  = 1'b0;
    endtask

    task automatic drive(input bit en, input longint x);
        data_i_en = en;
        data_i    = (WH+WW)'(x);
    endtask

    task automatic tick();
        bit pop;
        bit ov;
        bit os;
        int oq;
        int q;
        bit s;
        if (rec && data_o_en && data_o_rdy) got.push_back(int'($signed(data_o)));
        @(posedge clk);
        pop = (mq.size() > 0) && data_o_rdy;
        ov = pv[1]; oq = pq[1]; os = ps[1];
        pv[1] = pv[0]; pq[1] = pq[0]; ps[1] = ps[0];
        norm(longint'($signed(data_i)), q, s);
        pv[0] = data_i_en; pq[0] = q; ps[0] = s;
        if (pop) void'(mq.pop_front());
        msat = ov && os;
        if (ov) begin
            if (mq.size() < DP) mq.push_back(oq);
            else if (mdrop < 255) mdrop++;
        end
        #1;
        if (sat_flag) satseen++;
        check("valid", data_o_en, mq.size() > 0);
        check("level", fifo_level, mq.size());
        check("drop_cnt", drop_cnt, mdrop);
        check("sat_flag", sat_flag, msat);
        if (mq.size() > 0) check("data", $signed(data_o), mq[0]);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", data_o_en, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_data", $signed(data_o), 0);
        check("rst_sat", sat_flag, 0);
        data_i_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_sample(input bit en);
        logic [WH+WW-1:0] raw;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      drive(en, 16777215 - longint'($urandom_range(0, 40)));
        else if (r == 1) drive(en, -16777216 + longint'($urandom_range(0, 40)));
        else begin
            raw = (WH+WW)'($urandom);
            drive(en, longint'($signed(raw)));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        data_i_en  = 1'b0;
        data_i     = '0;
        data_o_rdy = 1'b0;
        rec        = 1'b0;
        satseen    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_valid", data_o_en, 0);
        check("init_level", fifo_level, 0);
        check("init_drop", drop_cnt, 0);
        check("init_data", $signed(data_o), 0);
        check("init_sat", sat_flag, 0);
        @(negedge clk) rst_n = 1'b1;

        // Rounding sequence and first-output latency
        data_o_rdy = 1'b1;
        got.delete();
        rec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rin[i]);
            tick();
            if (i == 1) check("lat_k1_valid", data_o_en, 0);
            if (i == 2) begin
                check("lat_k2_valid", data_o_en, 1);
                check("lat_k2_data", $signed(data_o), 1);
            end
        end
        drive(1'b0, 0);
        repeat (4) tick();
        rec = 1'b0;
        check("rnd_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            check("rnd_seq", (i < got.size()) ? got[i] : 32'h0BAD_0BAD, rexp[i]);

        // Saturation / wrap at the range limits
        got.delete();
        satseen = 0;
        rec = 1'b1;
        drive(1'b1, 16777215);
        tick();
        drive(1'b1, -16777216);
        tick();
        drive(1'b0, 0);
        repeat (4) tick();
        rec = 1'b0;
        check("sat_count", got.size(), 2);
`ifdef CIC_NORM_SAT_EN
        check("sat_pos", (got.size() > 0) ? got[0] : 32'h0BAD_0BAD, 524287);
        check("sat_pulses", satseen, 1);
`else
        check("wrap_pos", (got.size() > 0) ? got[0] : 32'h0BAD_0BAD, -524288);
        check("sat_pulses", satseen, 0);
`endif
        check("sat_neg", (got.size() > 1) ? got[1] : 32'h0BAD_0BAD, -524288);

        // Reset with three samples buffered
        data_o_rdy = 1'b0;
        for (int v = 7; v <= 9; v++) begin
            drive(1'b1, 32 * v);
            tick();
        end
        drive(1'b0, 0);
        repeat (2) tick();
        check("pre_rst_level", fifo_level, 3);
        async_reset();
        repeat (5) tick();
        check("post_rst_idle", data_o_en, 0);

        // Backpressure: six samples into a four-entry FIFO
        for (int v = 1; v <= 6; v++) begin
            drive(1'b1, 32 * v);
            tick();
        end
        drive(1'b0, 0);
        repeat (3) tick();
        check("bp_level", fifo_level, 4);
        check("bp_drop", drop_cnt, 2);
        data_o_rdy = 1'b1;
        got.delete();
        rec = 1'b1;
        repeat (6) tick();
        rec = 1'b0;
        check("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("bp_order", (i < got.size()) ? got[i] : 32'h0BAD_0BAD, i + 1);

        // Full FIFO with push and pop on the same edge
        data_o_rdy = 1'b0;
        for (int v = 101; v <= 104; v++) begin
            drive(1'b1, 32 * v);
            tick();
        end
        drive(1'b0, 0);
        repeat (3) tick();
        check("fp_full", fifo_level, 4);
        drive(1'b1, 32 * 105);
        tick();
        drive(1'b1, 32 * 106);
        tick();
        data_o_rdy = 1'b1;
        got.delete();
        rec = 1'b1;
        for (int v = 107; v <= 114; v++) begin
            drive(1'b1, 32 * v);
            tick();
            check("fp_level", fifo_level, 4);
        end
        drive(1'b0, 0);
        repeat (8) tick();
        rec = 1'b0;
        check("fp_drop", drop_cnt, 2);
        check("fp_count", got.size(), 14);
        for (int i = 0; i < 14; i++)
            check("fp_order", (i < got.size()) ? got[i] : 32'h0BAD_0BAD, 101 + i);

        // Random traffic against the model
        repeat (600) begin
            rand_sample($urandom_range(0, 3) != 0);
            data_o_rdy = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Drop counter saturation
        async_reset();
        data_o_rdy = 1'b0;
        repeat (300) begin
            rand_sample(1'b1);
            tick();
        end
        check("drop_sat", drop_cnt, 255);
        check("drop_sat_level", fifo_level, 4);
        repeat (10) tick();
        check("drop_hold", drop_cnt, 255);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
